// File: rtl/rx_framer_pkg.sv
// Shared definitions for the RX capture framer: header constants,
// FSM state encoding and the bit layout of header word 4.
// Pure declarations, no logic; imported by rx_framer.
package rx_framer_pkg;

    localparam logic [31:0] SYNC_DEFAULT = 32'hA5A5_1E55;
    localparam int          HDR_WORDS    = 6;

    // Validity flags packed above the 16-bit azimuth in header word 4
    localparam int W4_T_OK_BIT  = 16;
    localparam int W4_AZ_OK_BIT = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic logic [31:0] hdr_w4(input logic       az_ok,
                                           input logic       t_ok,
                                           input logic [15:0] az);
        logic [31:0] w;
        w               = 32'(az);
        w[W4_T_OK_BIT]  = t_ok;
        w[W4_AZ_OK_BIT] = az_ok;
        return w;
    endfunction

endpackage

// File: rtl/rx_framer_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW.
// Latency: a word written into an empty FIFO is visible on rd_data one cycle later.
// Backpressure: writes while full are dropped unless a read happens the same cycle.
// Ports: clk/srst (sync active-high), wr_en/wr_data push, rd_en pop,
//        rd_data head word (valid while !empty), empty/full/count status.
module sync_fifo_fwft #(
    parameter int W  = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [W-1:0]  r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_rd;
    logic          w_do_wr;

    // A read from an empty FIFO is ignored; a write into a full FIFO only
    // proceeds when a read frees a slot in the same cycle.
    assign w_do_rd = rd_en & (r_count != '0);
    assign w_do_wr = wr_en & ((r_count != DEPTH) | w_do_rd);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign empty   = (r_count == '0);
    assign full    = (r_count == DEPTH);
    assign count   = r_count;

endmodule

// File: rtl/rx_framer.sv
// Timestamped sample framer: 6-word header (sync, frame no., time, azimuth, length) then NSAMP samples.
// Latency: m_tvalid with header word 0 the cycle after an accepted trigger; samples are FIFO-buffered.
// Backpressure: m_tready stalls the output only; samples are never backpressured (FIFO depth >= NSAMP).
// Ports: clk/srst; enable/trig control; sec_l/ppstime_l/l_valid and azimuth/azimuth_vld
//        hold-register sources; samp_tdata/samp_tvalid sample input; m_t* output stream;
//        busy, frame_cnt, drop_cnt status.
module rx_framer
    import rx_framer_pkg::*;
#(
    parameter int          NSAMP   = 256,
    parameter int          FIFO_AW = 9,
    parameter logic [31:0] SYNC    = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        enable,
    input  logic        trig,
    input  logic [31:0] sec_l,
    input  logic [31:0] ppstime_l,
    input  logic        l_valid,
    input  logic [15:0] azimuth,
    input  logic        azimuth_vld,
    input  logic [31:0] samp_tdata,
    input  logic        samp_tvalid,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic [31:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    generate
        if (NSAMP < 1 || NSAMP > 65535) begin : g_bad_nsamp
            $error("rx_framer: NSAMP must be in 1..65535");
        end
        if ((1 << FIFO_AW) < NSAMP) begin : g_fifo_too_small
            $error("rx_framer: FIFO depth 2**FIFO_AW is smaller than NSAMP");
        end
    endgenerate

    localparam logic [15:0] NSAMP_W  = 16'(NSAMP);
    localparam logic [15:0] LAST_IDX = 16'(NSAMP - 1);
    localparam logic [2:0]  HDR_LAST = 3'(HDR_WORDS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_hdr_idx;
    logic [15:0]   r_cap_n;
    logic [15:0]   r_out_n;

    logic [31:0]   r_t_sec;
    logic [31:0]   r_t_pps;
    logic          r_t_ok;
    logic [15:0]   r_az;
    logic          r_az_ok;

    logic [31:0]   r_s_sec;
    logic [31:0]   r_s_pps;
    logic [15:0]   r_s_az;
    logic          r_s_t_ok;
    logic          r_s_az_ok;
    logic [31:0]   r_s_fcnt;

    logic [31:0]   r_frame_cnt;
    logic [15:0]   r_drop_cnt;

    logic          w_busy;
    logic          w_beat;
    logic          w_last_beat;
    logic          w_accept;
    logic          w_drop;
    logic          w_cap;
    logic          w_pop;
    logic [31:0]   w_hdr_word;
    logic [31:0]   w_fifo_data;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [FIFO_AW:0] w_fifo_count_unused;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_beat      = m_tvalid & m_tready;
    assign w_last_beat = (r_state == ST_DATA) & w_beat & m_tlast;
    // The final beat frees the framer in the same cycle, so a trigger
    // landing on it starts the next frame without an idle gap.
    assign w_accept    = trig & enable & (~w_busy | w_last_beat);
    assign w_drop      = trig & enable & w_busy & ~w_accept;
    // Capture window opens the cycle after acceptance (state has left IDLE)
    // and closes once NSAMP words are stored.
    assign w_cap       = w_busy & samp_tvalid & (r_cap_n != NSAMP_W) & ~w_fifo_full;
    assign w_pop       = (r_state == ST_DATA) & w_beat;

    sync_fifo_fwft #(
        .W  (32),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .srst    (srst),
        .wr_en   (w_cap),
        .wr_data (samp_tdata),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full),
        .count   (w_fifo_count_unused)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (srst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_HDR;
            ST_HDR:  if (w_beat && r_hdr_idx == HDR_LAST) w_next = ST_DATA;
            ST_DATA: if (w_last_beat) w_next = w_accept ? ST_HDR : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = 32'd0;
        m_tlast  = 1'b0;
        case (r_state)
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = w_hdr_word;
            end
            ST_DATA: begin
                m_tvalid = ~w_fifo_empty;
                m_tdata  = w_fifo_data;
                m_tlast  = ~w_fifo_empty & (r_out_n == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_hdr_word = 32'd0;
        case (r_hdr_idx)
            3'd0:    w_hdr_word = SYNC;
            3'd1:    w_hdr_word = r_s_fcnt;
            3'd2:    w_hdr_word = r_s_sec;
            3'd3:    w_hdr_word = r_s_pps;
            3'd4:    w_hdr_word = hdr_w4(r_s_az_ok, r_s_t_ok, r_s_az);
            3'd5:    w_hdr_word = 32'(NSAMP_W);
            default: w_hdr_word = 32'd0;
        endcase
    end

    // Beat/capture counters
    always_ff @(posedge clk) begin
        if (srst) begin
            r_hdr_idx <= '0;
            r_out_n   <= '0;
            r_cap_n   <= '0;
        end else if (w_accept) begin
            r_hdr_idx <= '0;
            r_out_n   <= '0;
            r_cap_n   <= '0;
        end else begin
            if (r_state == ST_HDR && w_beat) r_hdr_idx <= r_hdr_idx + 1'b1;
            if (w_pop)                       r_out_n   <= r_out_n + 1'b1;
            if (w_cap)                       r_cap_n   <= r_cap_n + 1'b1;
        end
    end

    // Hold registers, snapshot and status counters
    always_ff @(posedge clk) begin
        if (srst) begin
            r_t_sec     <= '0;
            r_t_pps     <= '0;
            r_t_ok      <= 1'b0;
            r_az        <= '0;
            r_az_ok     <= 1'b0;
            r_s_sec     <= '0;
            r_s_pps     <= '0;
            r_s_az      <= '0;
            r_s_t_ok    <= 1'b0;
            r_s_az_ok   <= 1'b0;
            r_s_fcnt    <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (l_valid) begin
                r_t_sec <= sec_l;
                r_t_pps <= ppstime_l;
                r_t_ok  <= 1'b1;
            end
            if (azimuth_vld) begin
                r_az    <= azimuth;
                r_az_ok <= 1'b1;
            end
            // Snapshot bypasses the hold regs when an update coincides with the trigger
            if (w_accept) begin
                r_s_sec     <= l_valid ? sec_l : r_t_sec;
                r_s_pps     <= l_valid ? ppstime_l : r_t_pps;
                r_s_t_ok    <= l_valid | r_t_ok;
                r_s_az      <= azimuth_vld ? azimuth : r_az;
                r_s_az_ok   <= azimuth_vld | r_az_ok;
                r_s_fcnt    <= r_frame_cnt;
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign busy      = w_busy;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_rx_framer.sv
module tb_rx_framer;

    localparam int NSAMP = 8;

    logic        clk = 1'b0;
    logic        srst;
    logic        enable;
    logic        trig;
    logic [31:0] sec_l;
    logic [31:0] ppstime_l;
    logic        l_valid;
    logic [15:0] azimuth;
    logic        azimuth_vld;
    logic [31:0] samp_tdata;
    logic        samp_tvalid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    rx_framer #(
        .NSAMP   (NSAMP),
        .FIFO_AW (4),
        .SYNC    (32'hA5A5_1E55)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .enable      (enable),
        .trig        (trig),
        .sec_l       (sec_l),
        .ppstime_l   (ppstime_l),
        .l_valid     (l_valid),
        .azimuth     (azimuth),
        .azimuth_vld (azimuth_vld),
        .samp_tdata  (samp_tdata),
        .samp_tvalid (samp_tvalid),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 driven by test

    // Reference model: what the stream should contain, derived from the stimulus
    logic [31:0] m_sec, m_pps, m_fcnt;
    logic [15:0] m_az, m_drop;
    logic        m_tok, m_azok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic model_reset();
        m_sec = 0; m_pps = 0; m_fcnt = 0; m_az = 0; m_drop = 0;
        m_tok = 0; m_azok = 0;
    endtask

    task automatic push_header();
        push_exp(32'hA5A5_1E55, 1'b0);
        push_exp(m_fcnt, 1'b0);
        push_exp(m_sec, 1'b0);
        push_exp(m_pps, 1'b0);
        push_exp({14'b0, m_azok, m_tok, m_az}, 1'b0);
        push_exp(32'(NSAMP), 1'b0);
        m_fcnt = m_fcnt + 1;
    endtask

    task automatic set_hold(input bit lv, input bit av, input logic [31:0] s,
                            input logic [31:0] p, input logic [15:0] a);
        if (lv) begin
            sec_l = s; ppstime_l = p; l_valid = 1'b1;
            m_sec = s; m_pps = p; m_tok = 1'b1;
        end
        if (av) begin
            azimuth = a; azimuth_vld = 1'b1;
            m_az = a; m_azok = 1'b1;
        end
    endtask

    task automatic start_frame(input bit lv, input bit av, input bit coincide, input bit samp_at_t,
                               input logic [31:0] s, input logic [31:0] p, input logic [15:0] a);
        if (!coincide && (lv || av)) begin
            @(posedge clk); #1;
            trig = 1'b0;
            set_hold(lv, av, s, p, a);
        end
        @(posedge clk); #1;
        l_valid = 1'b0; azimuth_vld = 1'b0;
        if (coincide) set_hold(lv, av, s, p, a);
        enable = 1'b1;
        trig = 1'b1;
        samp_tvalid = samp_at_t;   // trigger-cycle sample must be discarded
        samp_tdata = $urandom;
        push_header();
    endtask

    task automatic feed(input int gap_lo, input int gap_hi, input bit seq, input int extra,
                        input int drop_at, input bit noise);
        int n = 0;
        int k = 0;
        int gap = 0;
        while (n < NSAMP + extra) begin
            @(posedge clk); #1;
            l_valid = 1'b0; azimuth_vld = 1'b0;
            trig = (k == drop_at);
            if (trig && m_drop != 16'hFFFF) m_drop = m_drop + 1;
            if (noise && $urandom_range(0, 5) == 0)
                set_hold(1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom, 16'($urandom));
            if (gap == 0) begin
                samp_tvalid = 1'b1;
                samp_tdata = seq ? 32'(n + 1) : $urandom;
                if (n < NSAMP) push_exp(samp_tdata, n == NSAMP - 1);
                n++;
                gap = $urandom_range(gap_hi, gap_lo);
            end else begin
                samp_tvalid = 1'b0;
                gap--;
            end
            k++;
        end
        @(posedge clk); #1;
        samp_tvalid = 1'b0; trig = 1'b0; l_valid = 1'b0; azimuth_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout pending=%0d busy=%0d required=drained", name, exp_q.size(), busy);
        end
        chk({name, "_frame_cnt"}, frame_cnt, m_fcnt);
        chk({name, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    // Output ready generator
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = ~m_tready;
                2: m_tready = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    end

    // Monitor: scoreboard pop on every handshake, plus stall-stability check
    beat_t       mon_e;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    logic        prev_stall = 1'b0;

    always @(negedge clk) begin
        if (prev_stall && !srst) begin
            total++;
            if (!(m_tvalid && m_tdata == prev_d && m_tlast == prev_l)) begin
                bad++;
                $display("FAIL stall_hold actual=%0d/%h/%0d required=1/%h/%0d",
                         m_tvalid, m_tdata, m_tlast, prev_d, prev_l);
            end
        end
        if (!srst && m_tvalid && m_tready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_beat actual=%h/%0d required=no beat", m_tdata, m_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_tdata !== mon_e.d || m_tlast !== mon_e.l) begin
                    bad++;
                    $display("FAIL beat actual=%h/%0d required=%h/%0d", m_tdata, m_tlast, mon_e.d, mon_e.l);
                end
            end
        end
        prev_stall = m_tvalid && !m_tready && !srst;
        prev_d = m_tdata;
        prev_l = m_tlast;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        srst = 1'b1; enable = 1'b0; trig = 1'b0;
        sec_l = 0; ppstime_l = 0; l_valid = 1'b0;
        azimuth = 0; azimuth_vld = 1'b0;
        samp_tdata = 0; samp_tvalid = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        @(posedge clk); #1;
        srst = 1'b0;

        // No timebase/azimuth seen yet: header fields and flags zero
        rdy_mode = 0;
        start_frame(0, 0, 0, 0, 0, 0, 0);
        feed(0, 0, 0, 0, -1, 0);
        wait_idle("no_hold");

        // Known values, back-to-back samples 1..N, always ready
        start_frame(1, 1, 0, 0, 32'h10, 32'h2A, 16'h1234);
        feed(0, 0, 1, 0, -1, 0);
        wait_idle("basic");

        // Same with ready toggling
        rdy_mode = 1;
        start_frame(1, 1, 0, 0, 32'h10, 32'h2A, 16'h1234);
        feed(0, 0, 1, 0, -1, 0);
        wait_idle("toggle_rdy");

        // Randomized frames: bypass, trigger-cycle samples, surplus samples, noise updates
        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            start_frame($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, $urandom, $urandom, 16'($urandom));
            feed(0, $urandom_range(0, 3), 0, $urandom_range(0, 3), -1, 1);
            wait_idle("rand");
        end

        // Sparse samples: one every 5 cycles
        rdy_mode = 0;
        start_frame(1, 0, 0, 0, $urandom, $urandom, 0);
        feed(4, 4, 0, 0, -1, 0);
        wait_idle("gapped");

        // Trigger mid-frame is dropped; trigger on the tlast beat is accepted
        rdy_mode = 2;
        start_frame(1, 1, 0, 0, $urandom, $urandom, 16'($urandom));
        feed(0, 1, 0, 0, 2, 0);
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (m_tvalid && m_tready && m_tlast) begin
                trig = 1'b1;
                push_header();
                ok = 1;
            end
        end
        chk("tlast_seen", 32'(ok), 1);
        feed(0, 1, 0, 0, -1, 0);
        wait_idle("back2back");

        // enable low: trigger ignored and not counted
        @(posedge clk); #1;
        enable = 1'b0; trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("dis_busy", 32'(busy), 0);
        chk("dis_tvalid", 32'(m_tvalid), 0);
        chk("dis_frame_cnt", frame_cnt, m_fcnt);
        chk("dis_drop_cnt", 32'(drop_cnt), 32'(m_drop));
        enable = 1'b1;

        // Reset while data beat 3 is presented
        @(posedge clk); #1;
        rdy_mode = 3;
        m_tready = 1'b0;
        start_frame(1, 1, 0, 0, $urandom, $urandom, 16'($urandom));
        feed(0, 0, 0, 0, -1, 0);
        repeat (2) @(posedge clk);
        #1 m_tready = 1'b1;
        repeat (9) @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        chk("pre_rst_pending", 32'(exp_q.size()), 32'(NSAMP - 3));
        chk("pre_rst_tvalid", 32'(m_tvalid), 1);
        @(posedge clk); #1;
        srst = 1'b1;
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", 32'(m_tvalid), 0);
        chk("mid_rst_tlast", 32'(m_tlast), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 0);

        // Clean frame after reset: frame number 0, hold regs cleared
        rdy_mode = 2;
        start_frame(0, 0, 0, 0, 0, 0, 0);
        feed(0, 2, 0, 1, -1, 0);
        wait_idle("post_rst");

        repeat (5) @(negedge clk);
        chk("leftover", 32'(exp_q.size()), 0);
        chk("final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
